// File: rtl/fetch_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_issue_unit
//  Description : Producer side of the control unit's decode interface.
//                Fetches instruction words at the PC, presents opcode and
//                literal to the decoder for one execute cycle, applies the
//                decoder's load-PC request and holds the {Z,N,C,V} status.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_issue_unit #(
    parameter int         PC_W   = 8,
    parameter int         IW     = 15,
    parameter logic [6:0] NOP_OP = 7'h7F
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [IW-1:0]   imem_data,
    output logic [6:0]      opcode,
    output logic [PC_W-1:0] literal,
    output logic            issue,
    input  logic            lpc,
    input  logic [3:0]      alu_flags,
    input  logic            flags_we,
    output logic [3:0]      status,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Instruction register resets to an inert NOP with a zero literal.
    localparam logic [IW-1:0] c_ir_reset = {NOP_OP, {PC_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [IW-1:0]     r_ir;
    logic [IW-1:0]     w_ir_nxt;
    logic [3:0]        r_status;
    logic [3:0]        w_status_nxt;
    logic [PC_W-1:0]   w_lit;

    // Literal field of whatever instruction sits in the instruction register.
    assign w_lit = r_ir[PC_W-1:0];

    // State, PC, instruction and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= c_ir_reset;
            r_status <= 4'b0000;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_status <= w_status_nxt;
        end
    end

    // Next-state and output decode; everything holds unless a state acts.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_status_nxt = r_status;
        imem_req     = 1'b0;
        issue        = 1'b0;
        halted       = 1'b0;
        opcode       = NOP_OP;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                // run is deliberately ignored here: a started fetch completes.
                imem_req = 1'b1;
                if (imem_valid) begin
                    w_ir_nxt    = imem_data;
                    w_state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                issue  = 1'b1;
                opcode = r_ir[IW-1:PC_W];
                if (flags_we) begin
                    w_status_nxt = alu_flags;
                end
                // A jump to its own address can never make progress: stop.
                if (lpc && (w_lit == r_pc)) begin
                    w_state_nxt = S_HALT;
                end else begin
                    if (lpc) begin
                        w_pc_nxt = w_lit;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                    w_state_nxt = run ? S_FETCH : S_IDLE;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign literal   = w_lit;
    assign status    = r_status;
    assign pc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_issue_unit
//  Description : Scoreboard bench for fetch_issue_unit. A small decoder model
//                derives lpc/flags_we/alu_flags from opcode bits
//                (bit0 = lpc, bit1 = flags_we, bits[5:2] = alu_flags).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [14:0] imem_data = '0;
    logic [6:0]  opcode;
    logic [7:0]  literal;
    logic        issue;
    logic        lpc;
    logic [3:0]  alu_flags;
    logic        flags_we;
    logic [3:0]  status;
    logic [7:0]  pc;
    logic        halted;

    always #5 clk = ~clk;

    fetch_issue_unit #(
        .PC_W   (8),
        .IW     (15),
        .NOP_OP (7'h7F)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .opcode     (opcode),
        .literal    (literal),
        .issue      (issue),
        .lpc        (lpc),
        .alu_flags  (alu_flags),
        .flags_we   (flags_we),
        .status     (status),
        .pc         (pc),
        .halted     (halted)
    );

    // Decoder model: NOP_OP (7F) outside EXEC asserts lpc and flags_we,
    // so any sampling of them outside EXEC shows up as a wrong PC/status.
    always_comb begin
        lpc       = opcode[0];
        flags_we  = opcode[1];
        alu_flags = opcode[5:2];
    end

    // Instruction memory with a programmable number of wait cycles.
    logic [14:0] mem [0:255];
    int          mem_wait = 0;
    int          wait_cnt = 0;
    logic        mem_valid = 1'b0;
    logic        force_valid = 1'b0;

    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            if (wait_cnt < mem_wait) begin
                mem_valid = 1'b0;
                wait_cnt++;
            end else begin
                mem_valid = 1'b1;
                imem_data = mem[imem_addr];
                wait_cnt  = 0;
            end
        end else begin
            mem_valid = 1'b0;
            wait_cnt  = 0;
        end
    end

    assign imem_valid = mem_valid | force_valid;

    // Check bookkeeping.
    int nchk  = 0;
    int npass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard of expected issue events.
    typedef struct packed {
        logic [6:0] op;
        logic [7:0] lit;
        logic [7:0] pc;
        logic [3:0] st;
        logic [7:0] gap;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   last_issue = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic push(input logic [6:0] op, input logic [7:0] lit, input logic [7:0] p,
                        input logic [3:0] st, input logic [7:0] gap);
        exp_t e;
        e.op  = op;
        e.lit = lit;
        e.pc  = p;
        e.st  = st;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Monitor: every issue cycle pops one expectation and compares it.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [7:0]  gap_act;
        if (issue === 1'b1) begin
            if (sb.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_issue: got issue op=%h pc=%h expected none", opcode, pc);
            end else begin
                e       = sb.pop_front();
                gap_act = (e.gap == 8'd0) ? 8'd0 : 8'(cyc - last_issue);
                chk("issue_event", {29'd0, opcode, literal, pc, status, gap_act},
                    {29'd0, e.op, e.lit, e.pc, e.st, e.gap});
            end
            last_issue = cyc;
        end
    end

    // Keep run high until n issue cycles are seen; optionally drop run in the last.
    task automatic run_issues(input int n, input bit drop);
        int seen = 0;
        for (int k = 0; k < 60 && seen < n; k++) begin
            @(posedge clk); #1;
            if (issue === 1'b1) begin
                seen++;
                if (seen == n && drop) run = 1'b0;
            end
        end
        if (seen < n) begin
            nchk++;
            $display("FAIL issue_timeout: got %0d issues expected %0d", seen, n);
        end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 15'h0000;
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_issue",    issue,    1'b0);
        chk("rst_halted",   halted,   1'b0);
        chk("rst_opcode",   opcode,   7'h7F);
        chk("rst_literal",  literal,  8'h00);
        chk("rst_pc",       pc,       8'h00);
        chk("rst_status",   status,   4'h0);

        // Zero-wait memory: words 0..3, issue every second cycle
        for (int i = 0; i < 4; i++) begin
            mem[i] = 15'(i);
            push(7'h00, 8'(i), 8'(i), 4'h0, (i == 0) ? 8'd0 : 8'd2);
        end
        mem_wait = 0;
        run = 1'b1;
        run_issues(4, 1'b1);
        step();
        chk("seq_pc_end", pc, 8'h04);
        chk("seq_idle_req", imem_req, 1'b0);

        // Three wait cycles at address 4
        mem[4] = {7'h00, 8'h44};
        push(7'h00, 8'h44, 8'h04, 4'h0, 8'd0);
        mem_wait = 3;
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wait_cycle", {imem_req, imem_addr, opcode, issue}, {1'b1, 8'h04, 7'h7F, 1'b0});
        end
        run_issues(1, 1'b1);
        step();
        chk("wait_pc_end", pc, 8'h05);

        // Jump 5 -> 0x20 -> 0xFF, then 0xFF wraps to 0
        mem_wait  = 0;
        mem[5]    = {7'h01, 8'h20};
        mem[8'h20] = {7'h01, 8'hFF};
        mem[8'hFF] = {7'h00, 8'h00};
        push(7'h01, 8'h20, 8'h05, 4'h0, 8'd0);
        push(7'h01, 8'hFF, 8'h20, 4'h0, 8'd2);
        push(7'h00, 8'h00, 8'hFF, 4'h0, 8'd2);
        run = 1'b1;
        run_issues(3, 1'b1);
        step();
        chk("wrap_pc", pc, 8'h00);

        // Status write, hold, and simultaneous lpc + flags_we
        mem[0]     = {7'h22, 8'h00};
        mem[1]     = {7'h18, 8'h00};
        mem[2]     = {7'h0F, 8'h30};
        mem[8'h30] = {7'h00, 8'h00};
        push(7'h22, 8'h00, 8'h00, 4'h0, 8'd0);
        push(7'h18, 8'h00, 8'h01, 4'h8, 8'd2);
        push(7'h0F, 8'h30, 8'h02, 4'h8, 8'd2);
        push(7'h00, 8'h00, 8'h30, 4'h3, 8'd2);
        run = 1'b1;
        run_issues(4, 1'b1);
        step();
        chk("flags_status", status, 4'h3);
        chk("flags_pc", pc, 8'h31);

        // Self-jump at 0x10 halts permanently, even with run held high
        mem[8'h31] = {7'h01, 8'h10};
        mem[8'h10] = {7'h01, 8'h10};
        push(7'h01, 8'h10, 8'h31, 4'h3, 8'd0);
        push(7'h01, 8'h10, 8'h10, 4'h3, 8'd2);
        run = 1'b1;
        run_issues(2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("halt_hold", {halted, pc, imem_req, issue, opcode}, {1'b1, 8'h10, 1'b0, 1'b0, 7'h7F});
        end
        run   = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("halt_reset", {pc, halted, imem_req, status}, {8'h00, 1'b0, 1'b0, 4'h0});
        step();
        chk("halt_reset_idle", imem_req, 1'b0);

        // Drop run while fetching at pc 7: instruction still issues once
        mem[0]   = {7'h01, 8'h07};
        mem[7]   = {7'h00, 8'h55};
        mem_wait = 2;
        push(7'h01, 8'h07, 8'h00, 4'h0, 8'd0);
        push(7'h00, 8'h55, 8'h07, 4'h0, 8'd0);
        run = 1'b1;
        run_issues(1, 1'b0);
        step();
        chk("drop_fetch", {imem_req, imem_addr}, {1'b1, 8'h07});
        run = 1'b0;
        run_issues(1, 1'b0);
        step();
        chk("drop_pc", {pc, imem_req}, {8'h08, 1'b0});
        step();
        chk("drop_idle", imem_req, 1'b0);

        // Reset in the middle of a memory wait; late valid is ignored
        mem_wait = 5;
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        chk("rstwait_fetch", imem_req, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstwait_reset", {imem_req, pc}, {1'b0, 8'h00});
        force_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("late_valid", {imem_req, issue, pc}, {1'b0, 1'b0, 8'h00});
        end
        force_valid = 1'b0;
        step();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
